// File: rtl/fpu_pkg.sv
// Shared floating-point constants and the square-root operand classifier.
package fpu_pkg;

   localparam logic [31:0] QNAN      = 32'h7FC00000;
   localparam logic [31:0] PINF      = 32'h7F800000;
   localparam int          FSQRT_LAT = 2;

   typedef struct packed {
      logic        special;
      logic        nv;
      logic [31:0] value;
   } sqrt_class_t;

   // Operands the datapath cannot handle get their result decided here at acceptance.
   function automatic sqrt_class_t fp_classify(input logic [31:0] x);
      sqrt_class_t c;
      c.special = 1'b1;
      c.nv      = 1'b0;
      c.value   = QNAN;
      if (x[30:23] == 8'h00)
         c.value = {x[31], 31'b0};
      else if (x[30:23] == 8'hFF && x[22:0] != '0)
         c.value = QNAN;
      else if (x[31])
         c.nv = 1'b1;
      else if (x == PINF)
         c.value = PINF;
      else
         c.special = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/fsqrt.sv
// Two-cycle square root for positive normal single-precision operands, round to nearest.
module fsqrt (
   input  logic        clk,
   input  logic [31:0] a,
   output logic [31:0] y
);
   logic [31:0] a_q;
   logic [47:0] rad;
   logic [23:0] root;
   logic [26:0] rem;
   logic [26:0] trial;
   logic [24:0] root_rnd;
   logic [7:0]  exp_r;
   logic [31:0] y_d;
   wire         unused_ok = ^{a_q[31], root_rnd[23]};

   always_ff @(posedge clk) a_q <= a;

   always_comb begin
      // Odd biased exponent means an even unbiased one: no extra radicand shift.
      rad   = a_q[23] ? {1'b0, 1'b1, a_q[22:0], 23'b0} : {1'b1, a_q[22:0], 24'b0};
      rem   = '0;
      root  = '0;
      trial = '0;
      for (int i = 23; i >= 0; i--) begin
         rem   = {rem[24:0], rad[2*i+1 -: 2]};
         trial = {1'b0, root, 2'b01};
         if (rem >= trial) begin
            rem  = rem - trial;
            root = {root[22:0], 1'b1};
         end else begin
            root = {root[22:0], 1'b0};
         end
      end
      root_rnd = {1'b0, root} + {24'b0, (rem > {3'b0, root})};
      exp_r    = {1'b0, a_q[30:24]} + 8'd63 + {7'b0, a_q[23]};
      y_d      = root_rnd[24] ? {1'b0, exp_r + 8'd1, 23'b0} : {1'b0, exp_r, root_rnd[22:0]};
   end

   always_ff @(posedge clk) y <= y_d;

endmodule

// File: rtl/fsqrt_issue.sv
// Issue wrapper around fsqrt: special-operand bypass, aligned sideband pipeline,
// credit-guarded result FIFO with valid/ready handshakes on both sides.
module fsqrt_issue
   import fpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAGW  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_data,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_data,
   output logic [TAGW-1:0] out_tag,
   output logic            out_nv,
   output logic            busy
);
   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam int ENTW = 32 + TAGW + 1;
   localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
   localparam logic [PTRW-1:0] LAST_PTR = PTRW'(DEPTH - 1);

   logic            accept, push, pop;
   sqrt_class_t     cls;
   logic            s1_v, s2_v;
   logic [TAGW-1:0] s1_tag, s2_tag;
   logic            s1_sp, s2_sp, s1_nv, s2_nv;
   logic [31:0]     s1_val, s2_val;
   logic [31:0]     sqrt_y, push_data;
   logic [ENTW-1:0] mem [DEPTH];
   logic [ENTW-1:0] head;
   logic [PTRW-1:0] wptr, rptr;
   logic [CNTW-1:0] count, credits;

   // Credits count every slot a request may eventually occupy, so the FIFO cannot overflow.
   assign in_ready  = credits < DEPTH_C;
   assign busy      = credits != '0;
   assign accept    = in_valid & in_ready;
   assign cls       = fp_classify(in_data);
   assign out_valid = count != '0;
   assign pop       = out_valid & out_ready;
   assign push      = s2_v;
   assign push_data = s2_sp ? s2_val : sqrt_y;
   assign head      = out_valid ? mem[rptr] : '0;
   assign {out_data, out_tag, out_nv} = head;

   fsqrt u_fsqrt (
      .clk (clk),
      .a   (in_data),
      .y   (sqrt_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         s1_v <= accept;
         s2_v <= s1_v;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_tag <= in_tag;
         s1_sp  <= cls.special;
         s1_nv  <= cls.nv;
         s1_val <= cls.value;
      end
      s2_tag <= s1_tag;
      s2_sp  <= s1_sp;
      s2_nv  <= s1_nv;
      s2_val <= s1_val;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= {push_data, s2_tag, s2_sp & s2_nv};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         credits <= '0;
      end else begin
         if (push) wptr <= (wptr == LAST_PTR) ? '0 : wptr + PTRW'(1);
         if (pop)  rptr <= (rptr == LAST_PTR) ? '0 : rptr + PTRW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
         unique case ({accept, pop})
            2'b10:   credits <= credits + CNTW'(1);
            2'b01:   credits <= credits - CNTW'(1);
            default: credits <= credits;
         endcase
      end
   end

endmodule

// File: tb/tb_fsqrt_issue.sv
// Scoreboard bench for fsqrt_issue: expected results are queued on acceptance and
// compared as results are popped; credit and busy behaviour is checked every cycle.
`timescale 1ns/1ps
module tb_fsqrt_issue;
   localparam logic [31:0] QNAN = 32'h7FC00000;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, out_nv, busy;
   logic [31:0] in_data, out_data;
   logic [3:0]  in_tag, out_tag;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  t;
      logic        nv;
   } exp_t;

   exp_t        sbq[$];
   exp_t        e;
   logic [31:0] cur_res;
   logic        cur_nv;
   int          errors = 0;
   int          checks = 0;
   int          outstanding = 0;

   logic [31:0] spec_op  [7] = '{32'hBF800000, 32'h80000000, 32'h7F800000, 32'h7FC00001,
                                 32'hFF800000, 32'h00000400, 32'h3F800000};
   logic [31:0] spec_res [7] = '{QNAN, 32'h80000000, 32'h7F800000, QNAN,
                                 QNAN, 32'h00000000, 32'h3F800000};
   logic        spec_nv  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   always #5 clk = ~clk;

   fsqrt_issue #(.DEPTH(4), .TAGW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_nv    (out_nv),
      .busy      (busy)
   );

   // Inputs only change just after a rising edge, so the falling edge sees what the next edge transfers.
   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
         outstanding = 0;
      end else begin
         checks++;
         if (in_ready !== (outstanding < 4)) begin
            errors++;
            $display("FAIL credit_ready: in_ready=%b outstanding=%0d", in_ready, outstanding);
         end
         checks++;
         if (busy !== (outstanding != 0)) begin
            errors++;
            $display("FAIL busy: busy=%b outstanding=%0d", busy, outstanding);
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result: got data=%h tag=%h nv=%b with nothing expected",
                        out_data, out_tag, out_nv);
            end else begin
               e = sbq.pop_front();
               if ({out_data, out_tag, out_nv} !== e) begin
                  errors++;
                  $display("FAIL result: got data=%h tag=%h nv=%b want data=%h tag=%h nv=%b",
                           out_data, out_tag, out_nv, e.d, e.t, e.nv);
               end
            end
            outstanding--;
         end
         if (in_valid === 1'b1 && in_ready === 1'b1) begin
            sbq.push_back({cur_res, in_tag, cur_nv});
            outstanding++;
         end
      end
   end

   function automatic void gen_square(output logic [31:0] op, output logic [31:0] res);
      logic [11:0] q;
      logic [7:0]  re;
      logic [23:0] sq;
      int          e2;
      q   = 12'($urandom_range(4095, 2048));
      re  = 8'($urandom_range(150, 100));
      sq  = 24'(q) * 24'(q);
      res = {1'b0, re, q[10:0], 12'b0};
      if (sq[23]) begin
         e2 = 2 * int'(re) - 126;
         op = {1'b0, e2[7:0], sq[22:0]};
      end else begin
         e2 = 2 * int'(re) - 127;
         op = {1'b0, e2[7:0], sq[21:0], 1'b0};
      end
   endfunction

   function automatic void gen_special(output logic [31:0] op, output logic [31:0] res,
                                       output logic nv);
      logic        s;
      logic [22:0] m;
      s = 1'($urandom_range(1, 0));
      m = 23'($urandom_range(32'h7FFFFF, 1));
      case ($urandom_range(2, 0))
         0: begin op = {1'b1, 8'($urandom_range(254, 1)), m}; res = QNAN; nv = 1'b1; end
         1: begin op = {s, 8'hFF, m}; res = QNAN; nv = 1'b0; end
         default: begin op = {s, 8'h00, m}; res = {s, 31'b0}; nv = 1'b0; end
      endcase
   endfunction

   task automatic set_op(input int mode, input int idx);
      logic [31:0] op, res;
      logic        nv;
      if (mode == 2) begin
         op = spec_op[idx]; res = spec_res[idx]; nv = spec_nv[idx];
      end else if (mode == 1 && $urandom_range(3, 0) == 0) begin
         gen_special(op, res, nv);
      end else begin
         gen_square(op, res);
         nv = 1'b0;
      end
      in_data = op;
      cur_res = res;
      cur_nv  = nv;
      in_tag  = 4'(idx);
   endtask

   task automatic stream(input int mode, input int n, input int budget, input bit toggle,
                         output int acc, output int cyc);
      bit hs;
      acc = 0;
      cyc = 0;
      set_op(mode, 0);
      in_valid = 1'b1;
      while (acc < n && cyc < budget) begin
         @(negedge clk);
         hs = (in_valid === 1'b1) && (in_ready === 1'b1);
         @(posedge clk); #1;
         cyc++;
         if (toggle) out_ready = ~out_ready;
         if (hs) begin
            acc++;
            if (acc < n) set_op(mode, acc);
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      out_ready = 1'b1;
      while ((sbq.size() != 0 || busy !== 1'b0) && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      checks++;
      if (sbq.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL drain: pending=%0d busy=%b after %0d cycles", sbq.size(), busy, k);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
      checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL rst_out_tag: got %h want 0", out_tag); end
      checks++; if (out_nv !== 1'b0) begin errors++; $display("FAIL rst_out_nv: got %b want 0", out_nv); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      in_data   = 32'h40800000;
      in_tag    = 4'd3;
      cur_res   = 32'h40000000;
      cur_nv    = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat_e0: out_valid=%b want 0", out_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: busy=%b want 1", busy); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat_e1: out_valid=%b want 0", out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_lat_e2: out_valid=%b want 1", out_valid); end
      checks++; if (out_data !== 32'h40000000) begin errors++; $display("FAIL basic_data: got %h want 40000000", out_data); end
      checks++; if (out_tag !== 4'd3) begin errors++; $display("FAIL basic_tag: got %h want 3", out_tag); end
      checks++; if (out_nv !== 1'b0) begin errors++; $display("FAIL basic_nv: got %b want 0", out_nv); end
      wait_drain(20);
   endtask

   task automatic test_specials;
      int acc, cyc;
      out_ready = 1'b1;
      stream(2, 7, 20, 1'b0, acc, cyc);
      checks++; if (acc != 7) begin errors++; $display("FAIL specials_accepts: got %0d want 7", acc); end
      wait_drain(20);
   endtask

   task automatic test_backpressure;
      int          acc, cyc;
      logic [35:0] snap;
      out_ready = 1'b0;
      stream(0, 100, 10, 1'b0, acc, cyc);
      checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepts: got %0d want 4", acc); end
      @(negedge clk);
      snap = {out_data, out_tag};
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
         checks++; if ({out_data, out_tag} !== snap) begin errors++; $display("FAIL bp_stable: got %h want %h", {out_data, out_tag}, snap); end
      end
      @(posedge clk); #1;
      wait_drain(30);
   endtask

   task automatic test_back_to_back;
      int acc, cyc;
      out_ready = 1'b1;
      stream(1, 20, 40, 1'b0, acc, cyc);
      checks++; if (acc != 20) begin errors++; $display("FAIL b2b_accepts: got %0d want 20", acc); end
      checks++; if (cyc != 20) begin errors++; $display("FAIL b2b_cycles: got %0d want 20", cyc); end
      wait_drain(30);
   endtask

   task automatic test_reset_mid;
      int acc, cyc;
      out_ready = 1'b1;
      stream(0, 2, 10, 1'b0, acc, cyc);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0 cycle %0d", out_valid, i); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0 cycle %0d", busy, i); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1 cycle %0d", in_ready, i); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_full_toggle;
      int acc, cyc;
      out_ready = 1'b0;
      stream(1, 20, 300, 1'b1, acc, cyc);
      checks++; if (acc != 20) begin errors++; $display("FAIL toggle_accepts: got %0d want 20", acc); end
      wait_drain(50);
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      in_tag    = '0;
      cur_res   = '0;
      cur_nv    = 1'b0;
      #2;
      test_reset;
      test_basic;
      test_specials;
      test_backpressure;
      test_back_to_back;
      test_reset_mid;
      test_full_toggle;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d results never delivered", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fsqrt_issue.md
FSQRT_ISSUE -- requirements
Module: fsqrt_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning result FIFO entries and maximum in-flight operations.
REQ-002 SHALL have parameter TAGW, default 4, meaning tag width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request may be accepted.
REQ-007 SHALL have port in_data  input  32  IEEE-754 single operand.
REQ-008 SHALL have port in_tag  input  TAGW  opaque request tag.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_data  output  32  square-root result.
REQ-012 SHALL have port out_tag  output  TAGW  tag of the result.
REQ-013 SHALL have port out_nv  output  1  invalid-operation flag.
REQ-014 SHALL have port busy  output  1  any operation in flight or queued.

Function
REQ-015 SHALL accept a request on a rising edge where in_valid and in_ready are both 1.
REQ-016 SHALL drive the accepted operand into one fsqrt instance, which has 2-cycle latency and no stall.
REQ-017 SHALL carry valid, tag, special flag and special value through a 2-stage sideband pipeline aligned to fsqrt.
REQ-018 SHALL classify the operand combinationally at acceptance:
- exp==0 gives {s,31'b0}, nv=0;
- exp==255 with mant!=0 gives 0x7FC00000, nv=0;
- s=1 with exp!=0 gives 0x7FC00000, nv=1;
- 0x7F800000 gives 0x7F800000, nv=0;
- all other operands take the fsqrt result, nv=0.
REQ-019 SHALL select the special value over the fsqrt output at stage 2, then push {data,tag,nv} into the FIFO on the edge the sideband stage-2 valid is 1.
REQ-020 SHALL give latency acceptance edge N to FIFO write edge N+2, with out_valid high after edge N+2 at the earliest.
REQ-021 SHALL keep a credit count of (stage1 valid + stage2 valid + FIFO count), range 0..DEPTH.
REQ-022 SHALL set in_ready = (credits < DEPTH), computed from registered state only, with no dependence on out_ready.
REQ-023 SHALL never overflow the FIFO; each accepted request is guaranteed a slot.
REQ-024 SHALL present out_data/out_tag/out_nv from the FIFO head and pop on out_valid and out_ready.
REQ-025 SHALL handle push and pop on the same edge with count unchanged, including at count DEPTH and count 0 (pop ignored when empty).
REQ-026 SHALL wrap FIFO read/write pointers modulo DEPTH.
REQ-027 SHALL hold out_data/out_tag/out_nv stable while out_valid and not out_ready.
REQ-028 SHALL deliver results in acceptance order.
REQ-029 SHALL set busy = (credits != 0).

Reset
REQ-030 SHALL, while rst is 1, clear sideband valids, FIFO pointers, count and credits, and drive in_ready=1, out_valid=0, busy=0, out_data=0, out_tag=0, out_nv=0.
REQ-031 SHALL discard in-flight operations on reset mid-operation; stale fsqrt outputs SHALL never be pushed after reset release.
REQ-032 SHALL leave the fsqrt instance and FIFO data storage unreset.

Structure
REQ-033 SHALL place constants QNAN=32'h7FC00000, PINF=32'h7F800000 and FSQRT_LAT=2 in the shared package fpu_pkg.
REQ-034 SHALL instantiate exactly one sub-module, fsqrt, unmodified; the FIFO and classifier SHALL be inline.

Verification
REQ-035 SHALL cover: 0x40800000 tag 3 accepted edge 0, out_ready=1 -> out_valid after edge 2, out_data 0x40000000, tag 3, nv 0.
REQ-036 SHALL cover: 0xBF800000 -> 0x7FC00000 nv 1; 0x80000000 -> 0x80000000 nv 0; 0x7F800000 -> 0x7F800000 nv 0.
REQ-037 SHALL cover: out_ready=0 with in_valid held for 10 cycles -> exactly 4 accepted, in_ready 0 thereafter, out_data stable; release -> 4 results in tag order.
REQ-038 SHALL cover: back-to-back stream of 20 operands with out_ready=1 -> one accept per cycle and 20 in-order results matching a reference model.
REQ-039 SHALL cover: rst pulse one cycle after 2 accepts -> out_valid stays 0, busy 0, in_ready 1, and no result emerges within 5 cycles.
REQ-040 SHALL cover: FIFO full with out_ready toggling every cycle while requests continue -> no loss, no duplicate, in_ready never 1 with credits==4.
